// File: rtl/spi_oled_pkg.sv
// Shared types for the OLED SPI receive path: FIFO entry layout and receiver FSM states.
package spi_oled_pkg;

  localparam int SPI_BYTE_BITS = 8;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/spi_oled_rx_fifo.sv
// First-word-fall-through FIFO of rx_entry_t; pointers carry one extra wrap bit for full/empty.
module spi_oled_rx_fifo
  import spi_oled_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  rx_entry_t i_wrEntry,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output rx_entry_t o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  rx_entry_t   r_mem [DEPTH];
  logic        w_doPush;
  logic        w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_head   = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_wrEntry;
  end

endmodule

// File: rtl/spi_oled_rx.sv
// Mode-0 SPI target for the OLED link: oversampled on clk, bytes tagged cmd/data into a FIFO.
// Optional byte statistics outputs when SPI_OLED_RX_STATS_EN is defined.
module spi_oled_rx
  import spi_oled_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        mosi,
  input  logic        cs_n,
  input  logic        dc,
  output logic [7:0]  rx_data,
  output logic        rx_dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        overrun,
  output logic        frame_err
`ifdef SPI_OLED_RX_STATS_EN
  ,
  output logic [15:0] cmd_count,
  output logic [15:0] data_count
`endif
);

  logic [SYNC_STAGES-1:0] r_clkSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic [SYNC_STAGES-1:0] r_dcSync;
  logic [SYNC_STAGES-1:0] r_csnSync;
  logic                   r_clkPrev;

  rx_state_t              r_state;
  rx_state_t              w_nextState;
  logic [2:0]             r_bitCnt;
  logic [2:0]             w_nextBitCnt;
  logic [SPI_BYTE_BITS-2:0] r_shift;
  logic [SPI_BYTE_BITS-2:0] w_nextShift;

  logic      w_clkS;
  logic      w_mosiS;
  logic      w_dcS;
  logic      w_csnS;
  logic      w_clkRise;
  logic      w_push;
  logic      w_pop;
  logic      w_full;
  logic      w_empty;
  rx_entry_t w_pushEntry;
  rx_entry_t w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clkSync  <= '0;
      r_mosiSync <= '0;
      r_dcSync   <= '0;
      r_csnSync  <= '1;
      r_clkPrev  <= 1'b0;
    end else begin
      r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], spi_clk};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
      r_dcSync   <= {r_dcSync[SYNC_STAGES-2:0], dc};
      r_csnSync  <= {r_csnSync[SYNC_STAGES-2:0], cs_n};
      r_clkPrev  <= w_clkS;
    end
  end

  // mosi/dc come from the same stage as spi_clk so the sampled bit lines up with its edge.
  assign w_clkS    = r_clkSync[SYNC_STAGES-1];
  assign w_mosiS   = r_mosiSync[SYNC_STAGES-1];
  assign w_dcS     = r_dcSync[SYNC_STAGES-1];
  assign w_csnS    = r_csnSync[SYNC_STAGES-1];
  assign w_clkRise = w_clkS && !r_clkPrev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_nextState;
      r_bitCnt <= w_nextBitCnt;
      r_shift  <= w_nextShift;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextBitCnt = r_bitCnt;
    w_nextShift  = r_shift;
    w_push       = 1'b0;
    frame_err    = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextBitCnt = '0;
        if (!w_csnS) w_nextState = SHIFT;
      end
      SHIFT: begin
        // Deselect takes priority over a coincident clock edge.
        if (w_csnS) begin
          w_nextState  = IDLE;
          w_nextBitCnt = '0;
          frame_err    = (r_bitCnt != 3'd0);
        end else if (w_clkRise) begin
          w_nextShift  = {r_shift[SPI_BYTE_BITS-3:0], w_mosiS};
          w_nextBitCnt = r_bitCnt + 3'd1;
          w_push       = (r_bitCnt == 3'(SPI_BYTE_BITS - 1));
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_pushEntry.dc   = w_dcS;
  assign w_pushEntry.data = {r_shift, w_mosiS};

  spi_oled_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_wrEntry(w_pushEntry),
    .i_pop    (w_pop),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_head   (w_head)
  );

  assign rx_valid = !w_empty;
  assign w_pop    = rx_valid && rx_ready;
  assign rx_data  = w_head.data;
  assign rx_dc    = w_head.dc;
  assign overrun  = w_push && w_full && !w_pop;

`ifdef SPI_OLED_RX_STATS_EN
  logic        w_pushOk;
  logic [15:0] r_cmdCount;
  logic [15:0] r_dataCount;

  assign w_pushOk = w_push && !overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmdCount  <= '0;
      r_dataCount <= '0;
    end else if (w_pushOk) begin
      if (w_pushEntry.dc) begin
        if (r_dataCount != 16'hFFFF) r_dataCount <= r_dataCount + 16'd1;
      end else begin
        if (r_cmdCount != 16'hFFFF) r_cmdCount <= r_cmdCount + 16'd1;
      end
    end
  end

  assign cmd_count  = r_cmdCount;
  assign data_count = r_dataCount;
`endif

endmodule

// File: tb/tb_spi_oled_rx.sv
// Directed self-checking bench for spi_oled_rx; spi_clk runs at clk/8, outputs sampled on negedge.
module tb_spi_oled_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_clk;
  logic       mosi;
  logic       cs_n;
  logic       dc;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       frame_err;
`ifdef SPI_OLED_RX_STATS_EN
  logic [15:0] cmd_count;
  logic [15:0] data_count;
`endif

  int checks = 0;
  int fails = 0;
  int frameErrCnt = 0;
  int overrunCnt = 0;
  int fe0;
  int ov0;
  logic [8:0] got[$];

  spi_oled_rx #(
    .FIFO_DEPTH (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_clk  (spi_clk),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .dc       (dc),
    .rx_data  (rx_data),
    .rx_dc    (rx_dc),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .frame_err(frame_err)
`ifdef SPI_OLED_RX_STATS_EN
    ,
    .cmd_count (cmd_count),
    .data_count(data_count)
`endif
  );

  always #5 clk = ~clk;

  // Records pulses and every accepted FIFO entry; inputs only change on negedge, so +2 is stable.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (frame_err) frameErrCnt++;
      if (overrun) overrunCnt++;
      if (rx_valid && rx_ready) got.push_back({rx_dc, rx_data});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spiBit(input logic b);
    mosi = b;
    waitCycles(4);
    spi_clk = 1'b1;
    waitCycles(4);
    spi_clk = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic d);
    dc = d;
    for (int i = 7; i >= 0; i--) spiBit(b[i]);
  endtask

  task automatic csLow();
    cs_n = 1'b0;
    waitCycles(4);
  endtask

  task automatic csHigh();
    waitCycles(4);
    cs_n = 1'b1;
    waitCycles(6);
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0;
    spi_clk = 1'b0;
    mosi = 1'b0;
    cs_n = 1'b1;
    dc = 1'b0;
    rx_ready = 1'b0;
    waitCycles(3);

    checkOutput("rst_data", 32'(rx_data), 32'h0);
    checkOutput("rst_dc", 32'(rx_dc), 32'h0);
    checkOutput("rst_valid", 32'(rx_valid), 32'h0);
    checkOutput("rst_overrun", 32'(overrun), 32'h0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    waitCycles(2);

    // Single 0xA5 command byte with the last bit driven by hand to measure latency.
    $display("[TB] single byte 0xA5");
    pat = 8'hA5;
    csLow();
    dc = 1'b0;
    for (int i = 7; i >= 1; i--) spiBit(pat[i]);
    mosi = pat[0];
    waitCycles(4);
    spi_clk = 1'b1;
    waitCycles(2);
    checkOutput("lat_before", 32'(rx_valid), 32'h0);
    waitCycles(1);
    checkOutput("lat_valid", 32'(rx_valid), 32'h1);
    checkOutput("a5_data", 32'(rx_data), 32'hA5);
    checkOutput("a5_dc", 32'(rx_dc), 32'h0);
    waitCycles(1);
    spi_clk = 1'b0;
    csHigh();
    checkOutput("a5_no_frame_err", 32'(frameErrCnt), 32'h0);
    rx_ready = 1'b1;
    waitCycles(1);
    rx_ready = 1'b0;
    checkOutput("a5_drained", 32'(rx_valid), 32'h0);
    checkOutput("a5_count", 32'(got.size()), 32'h1);
    checkOutput("a5_entry", 32'(got[0]), 32'h0A5);

    $display("[TB] back-to-back 0x3C/0x81");
    got.delete();
    rx_ready = 1'b1;
    csLow();
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h81, 1'b0);
    csHigh();
    checkOutput("b2b_count", 32'(got.size()), 32'h2);
    checkOutput("b2b_first", 32'(got[0]), 32'h13C);
    checkOutput("b2b_second", 32'(got[1]), 32'h081);
    checkOutput("b2b_no_frame_err", 32'(frameErrCnt), 32'h0);

    $display("[TB] truncated byte then 0xF0");
    got.delete();
    fe0 = frameErrCnt;
    csLow();
    dc = 1'b0;
    for (int i = 0; i < 5; i++) spiBit(1'b1);
    csHigh();
    checkOutput("trunc_frame_err", 32'(frameErrCnt - fe0), 32'h1);
    checkOutput("trunc_no_push", 32'(got.size()), 32'h0);
    csLow();
    applyStimulus(8'hF0, 1'b0);
    csHigh();
    checkOutput("f0_count", 32'(got.size()), 32'h1);
    checkOutput("f0_entry", 32'(got[0]), 32'h0F0);
    checkOutput("f0_frame_err_once", 32'(frameErrCnt - fe0), 32'h1);

    $display("[TB] overrun with five data bytes");
    rx_ready = 1'b0;
    got.delete();
    ov0 = overrunCnt;
    csLow();
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1);
    csHigh();
    checkOutput("ovr_pulse", 32'(overrunCnt - ov0), 32'h1);
    checkOutput("ovr_head", 32'(rx_data), 32'h01);
    checkOutput("ovr_valid", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    waitCycles(6);
    rx_ready = 1'b0;
    checkOutput("ovr_drain_count", 32'(got.size()), 32'h4);
    for (int i = 0; i < 4; i++) checkOutput("ovr_drain_entry", 32'(got[i]), 32'h100 + 32'(i + 1));
    checkOutput("ovr_empty", 32'(rx_valid), 32'h0);
`ifdef SPI_OLED_RX_STATS_EN
    checkOutput("stats_cmd", 32'(cmd_count), 32'd3);
    checkOutput("stats_data", 32'(data_count), 32'd5);
`endif

    $display("[TB] reset mid-byte then 0x5A");
    fe0 = frameErrCnt;
    csLow();
    dc = 1'b0;
    for (int i = 0; i < 4; i++) spiBit(1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_data", 32'(rx_data), 32'h0);
    checkOutput("mid_rst_valid", 32'(rx_valid), 32'h0);
    checkOutput("mid_rst_frame_err", 32'(frame_err), 32'h0);
    cs_n = 1'b1;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(4);
`ifdef SPI_OLED_RX_STATS_EN
    checkOutput("stats_rst_cmd", 32'(cmd_count), 32'd0);
    checkOutput("stats_rst_data", 32'(data_count), 32'd0);
`endif
    got.delete();
    rx_ready = 1'b1;
    csLow();
    applyStimulus(8'h5A, 1'b0);
    csHigh();
    checkOutput("post_rst_count", 32'(got.size()), 32'h1);
    checkOutput("post_rst_entry", 32'(got[0]), 32'h05A);
    checkOutput("post_rst_no_frame_err", 32'(frameErrCnt - fe0), 32'h0);
`ifdef SPI_OLED_RX_STATS_EN
    checkOutput("stats_post_cmd", 32'(cmd_count), 32'd1);
    checkOutput("stats_post_data", 32'(data_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_oled_rx.md
Name: spi_oled_rx

Overview:
- SPI target (receive side) matching the OLED link the chip drives: oversamples oled_clk/mosi/dc/cs_n on the system clock and reassembles MSB-first bytes tagged command/data.
- Feeds a small FIFO with a ready/valid output.
- Used for on-board loopback (chip's own OLED pins jumpered back into spare inputs) and as the synthesizable bus monitor in benches.

Parameters:
- FIFO_DEPTH, 4, entries in output FIFO (power of two, ≥2)
- SYNC_STAGES, 2, flops per input synchronizer (≥2)

Ports:
- clk  in  1  system clock; must run ≥4× spi_clk
- rst_n  in  1  reset, asynchronous, active-low
- spi_clk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
- mosi  in  1  serial data, MSB first
- cs_n  in  1  chip select, active-low
- dc  in  1  0 = command byte, 1 = data byte
- rx_data  out  8  FIFO head byte
- rx_dc  out  1  dc tag of FIFO head
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts head when rx_valid & rx_ready
- overrun  out  1  one-cycle pulse: completed byte dropped, FIFO full
- frame_err  out  1  one-cycle pulse: cs_n deasserted mid-byte

Behaviour:
- Reset values: rx_data=0, rx_dc=0, rx_valid=0, overrun=0, frame_err=0.
- Reset state: FIFO empty, bit counter 0, state IDLE, synchronizers cleared to spi_clk=0, cs_n=1.
- Async reset mid-byte: partial byte discarded, FIFO contents lost.
- Inputs: spi_clk, mosi, cs_n, dc each pass through SYNC_STAGES flops.
- Edge detect: spi_clk rise = synced value 1 and previous synced value 0.
- mosi/dc are taken from the same synchronized stage as spi_clk, so they stay aligned.
- FSM IDLE:
  - bit_cnt held 0.
  - synced cs_n=0 → SHIFT.
- FSM SHIFT, on each detected spi_clk rise:
  - shift_reg <= {shift_reg[6:0], mosi_s}
  - bit_cnt <= bit_cnt+1 (3-bit, wraps 7→0)
- Byte complete, on the rise where bit_cnt==7:
  - push {dc_s, byte} to FIFO.
  - dc sampled on the 8th rise only.
  - Stay in SHIFT; back-to-back bytes need no cs_n toggle.
- Synced cs_n=1 while in SHIFT:
  - → IDLE.
  - If bit_cnt≠0: frame_err pulses the same cycle and the partial byte is discarded.
  - cs_n rise and spi_clk rise detected in the same cycle: cs_n wins; the edge is ignored.
- Latency: rx_valid rises the cycle after the clk cycle in which the 8th rise is detected (FIFO previously empty).
- FIFO (first-word-fall-through):
  - pop on rx_valid & rx_ready.
  - push when full and no pop in that cycle: byte dropped, overrun pulses 1 cycle, contents unchanged.
  - push and pop in the same cycle when full: both succeed, count unchanged.
  - push and pop in the same cycle when empty: no bypass; the byte is written and rx_valid rises next cycle.
  - Pointers are log2(FIFO_DEPTH) bits with one extra wrap bit for full/empty.
- spi_clk falling edges are ignored.

Optional Feature:
- Macro: SPI_OLED_RX_STATS_EN.
- Defined:
  - extra outputs cmd_count[15:0] and data_count[15:0], reset 0.
  - each increments on every byte pushed into the FIFO, per its dc tag; dropped (overrun) bytes are not counted.
  - counters saturate at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package spi_oled_pkg:
  - typedef rx_entry_t packed struct {logic dc; logic [7:0] data;}
  - enum rx_state_t {IDLE, SHIFT}
  - localparam SPI_BYTE_BITS=8
- Sub-module spi_oled_rx_fifo: parameterized sync FIFO of rx_entry_t (push, pop, full, empty, head).
- Top-level holds the synchronizers, edge detect, FSM and shift register.

Test Plan:
- cs_n=0, dc=0, shift 0xA5, spi_clk = clk/8 → exactly one rx_valid entry: rx_data=0xA5, rx_dc=0; valid rises 1 cycle after the 8th detected rise.
- Under one cs_n low, back-to-back 0x3C (dc=1) then 0x81 (dc=0), rx_ready=1 → two entries in order: {1,0x3C}, {0,0x81}; no frame_err.
- cs_n=0, send 5 bits, raise cs_n → frame_err single pulse, no FIFO push; next full byte 0xF0 → rx_data=0xF0.
- rx_ready=0, send 5 bytes 0x01..0x05 → FIFO holds 0x01..0x04, overrun pulses once at the 5th byte; draining yields 0x01..0x04.
- Assert rst_n=0 after 4 bits of a byte, then release → all outputs at reset values; a following byte 0x5A is received cleanly.
- With SPI_OLED_RX_STATS_EN: send 3 command + 2 data bytes → cmd_count=3, data_count=2; overrun-dropped bytes are not counted.
